riscv_i32_fetch_data_queue: RTL
===============================

# riscv_i32_fetch_data_queue

Parametrised, registered successor to the combinational fetch-data stage. Sits between the instruction-fetch response port and the decode stage, buffering up to `DEPTH` fetch responses with their PC and branch-prediction metadata. It adds epoch-tag filtering of stale responses after flushes and a debug-instruction injection path. It presents one fetch-data entry per cycle to decode.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, 2..16.
- `TAG_W`, 2: width of the fetch tag / epoch counter.

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `resp_valid`  in  1  fetch response present this cycle.
- `resp_data`  in  32  instruction word, aligned to bit 0.
- `resp_error`  in  1  fetch access fault.
- `resp_tag`  in  TAG_W  epoch tag returned with response.
- `resp_pc`  in  32  address of the response.
- `resp_debug_fetch`  in  1  response is a debug-ROM fetch.
- `resp_predicted_branch`  in  1  branch predicted at this PC.
- `resp_pc_if_mispredicted`  in  32  recovery PC.
- `flush`  in  1  exec mispredict, trap or trap-return.
- `dbg_valid`  in  1  debug instruction injection.
- `dbg_data`  in  32  injected instruction.
- `dbg_op`  in  2  debug op.
- `dbg_arg`  in  16  debug op argument.
- `dec_ready`  in  1  decode consumes the head entry this cycle.
- `epoch`  out  TAG_W  current epoch; fetch unit tags requests with it.
- `fetch_ready`  out  1  `count < DEPTH`; fetch may issue.
- `fd_valid`, `fd_pc`[32], `fd_data`[32], `fd_error`, `fd_predicted_branch`, `fd_pc_if_mispredicted`[32]  out  head entry to decode.
- `fd_debug_valid`, `fd_debug_op`[2], `fd_debug_arg`[16]  out  debug injection fields.
- `fd_flush`  out  1  flush indication to decode.
- `overflow`  out  1  sticky: response accepted while full.

## Operation
- Circular buffer: `rd_ptr`, `wr_ptr` (log2 DEPTH bits, wrap naturally), `count` (log2 DEPTH + 1 bits).
- Enqueue: `resp_valid && resp_tag == epoch && !flush && count < DEPTH`.
- Response with a stale tag is silently dropped. So is any response arriving in a flush cycle.
- Response that is valid and current while full is dropped and sets `overflow`, which stays set until reset.
- Debug fetch rewrite at enqueue: if `resp_debug_fetch` and `resp_pc[7:0] != 0`, store data `32'h00100073` (ebreak). If `resp_pc[7:0] == 0`, store `resp_data`.
- Dequeue: `fd_valid && dec_ready && !dbg_valid && !flush`.
- Simultaneous enqueue and dequeue when full is not permitted. Enqueue requires `count < DEPTH` from the start of the cycle.
- Flush: `count <= 0`, `rd_ptr <= wr_ptr`, and `epoch <= epoch + 1` (wraps mod 2^TAG_W).
- Debug injection has priority over queue output:
  - `fd_valid = 1`, `fd_data = dbg_data`, debug fields driven from the inputs.
  - `fd_pc` is the head PC.
  - The queue is held: no dequeue, though enqueue still proceeds.
- Flush during `dbg_valid`: the flush still clears the queue; the debug output is unaffected.
- Priority on `fd_valid`: `dbg_valid` (1) > `flush` (0) > `count != 0`.

## Timing
- Reset values:
  - All pointers, `count`, `epoch` and `overflow` are 0.
  - `fd_valid = 0`, `fetch_ready = 1`, `fd_flush = 0`.
  - Data outputs are 0 when the queue is empty and no debug injection is active.
- Latency: a response enqueued in cycle N is visible on `fd_*` in cycle N+1.
- `fd_*` are driven from registered storage (head entry) muxed combinationally with `dbg_*`.
- `fd_flush = flush`, combinational, same cycle. `fd_valid` is forced 0 in that cycle unless `dbg_valid`.
- `fetch_ready` and `epoch` are registered-state decodes with no combinational input path.
- Epoch wrap: a response tagged with epoch-2^TAG_W is indistinguishable from the current epoch. The fetch unit guarantees fewer than 2^TAG_W − 1 flushes while a request is outstanding.

## Structure
- Shared package: the fetch-data entry struct (pc, data, error, predicted_branch, pc_if_mispredicted), the debug-op encodings, and the constant `EBREAK = 32'h00100073`.
- One sub-module: `riscv_i32_fetch_data_queue_storage`, a DEPTH×entry register array with a write port and an asynchronous read port. Pointers, epoch and the output mux remain in the top module.

## Test plan
- Reset, then enqueue PCs 0x100, 0x104, 0x108 with tag 0 and `dec_ready = 1` -> `fd_pc` reads 0x100, 0x104, 0x108 on consecutive cycles, each one cycle after its enqueue.
- DEPTH=4 with `dec_ready = 0`, four responses -> `fetch_ready = 0`; a fifth response -> `overflow = 1`, the head remains 0x100, `count` remains 4.
- Queue holds 3 entries, pulse `flush` -> `fd_flush = 1` and `fd_valid = 0` that cycle; next cycle `count = 0` and `epoch = 1`; a later response with tag 0 is dropped and one with tag 1 is accepted.
- Debug fetch at pc 0x800 with data 0x12345678 -> output 0x12345678; at pc 0x804 -> output 0x00100073.
- `dbg_valid = 1` with data 0x7B200073 and 2 entries queued, `dec_ready = 1` for 3 cycles -> the debug data is shown and `count` remains 2; after `dbg_valid` drops, the head entry is presented unchanged.
- Deassert `reset_n` asynchronously mid-stream with 2 entries queued and `epoch = 3` -> all outputs are at reset values immediately, before the next clock edge.

Source files
------------

// File: rtl/riscv_i32_fetch_data_queue_pkg.sv
// Shared types and constants for the fetch-data queue: entry layout, debug ops, ebreak encoding.
package riscv_i32_fetch_data_queue_pkg;

  localparam logic [31:0] EBREAK = 32'h00100073;

  typedef enum logic [1:0] {
    DbgOpNone   = 2'd0,
    DbgOpHalt   = 2'd1,
    DbgOpStep   = 2'd2,
    DbgOpResume = 2'd3
  } dbg_op_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic        error;
    logic        predicted_branch;
    logic [31:0] pc_if_mispredicted;
  } fd_entry_t;

  // Debug-ROM fetches away from the ROM base are replaced by ebreak.
  function automatic logic [31:0] rewrite_debug_fetch(input logic        debug_fetch,
                                                      input logic [31:0] pc,
                                                      input logic [31:0] data);
    return (debug_fetch && (pc[7:0] != 8'h00)) ? EBREAK : data;
  endfunction

endpackage

// File: rtl/riscv_i32_fetch_data_queue_if.sv
// Fetch-response, debug-injection and decode-side signals of the fetch-data queue.
interface riscv_i32_fetch_data_queue_if
  import riscv_i32_fetch_data_queue_pkg::*;
#(
  parameter int unsigned TAG_W = 2
);
  logic             resp_valid;
  logic [31:0]      resp_data;
  logic             resp_error;
  logic [TAG_W-1:0] resp_tag;
  logic [31:0]      resp_pc;
  logic             resp_debug_fetch;
  logic             resp_predicted_branch;
  logic [31:0]      resp_pc_if_mispredicted;
  logic             flush;
  logic             dbg_valid;
  logic [31:0]      dbg_data;
  dbg_op_e          dbg_op;
  logic [15:0]      dbg_arg;
  logic             dec_ready;

  logic [TAG_W-1:0] epoch;
  logic             fetch_ready;
  logic             fd_valid;
  logic [31:0]      fd_pc;
  logic [31:0]      fd_data;
  logic             fd_error;
  logic             fd_predicted_branch;
  logic [31:0]      fd_pc_if_mispredicted;
  logic             fd_debug_valid;
  dbg_op_e          fd_debug_op;
  logic [15:0]      fd_debug_arg;
  logic             fd_flush;
  logic             overflow;

  modport master (
    output resp_valid, resp_data, resp_error, resp_tag, resp_pc, resp_debug_fetch,
           resp_predicted_branch, resp_pc_if_mispredicted, flush, dbg_valid, dbg_data,
           dbg_op, dbg_arg, dec_ready,
    input  epoch, fetch_ready, fd_valid, fd_pc, fd_data, fd_error, fd_predicted_branch,
           fd_pc_if_mispredicted, fd_debug_valid, fd_debug_op, fd_debug_arg, fd_flush, overflow
  );

  modport slave (
    input  resp_valid, resp_data, resp_error, resp_tag, resp_pc, resp_debug_fetch,
           resp_predicted_branch, resp_pc_if_mispredicted, flush, dbg_valid, dbg_data,
           dbg_op, dbg_arg, dec_ready,
    output epoch, fetch_ready, fd_valid, fd_pc, fd_data, fd_error, fd_predicted_branch,
           fd_pc_if_mispredicted, fd_debug_valid, fd_debug_op, fd_debug_arg, fd_flush, overflow
  );

endinterface

// File: rtl/riscv_i32_fetch_data_queue_storage.sv
// DEPTH-entry register array holding fetch-data entries; one write port, one async read port.
module riscv_i32_fetch_data_queue_storage
  import riscv_i32_fetch_data_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  fd_entry_t                i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output fd_entry_t                o_rdata
);

  fd_entry_t r_mem [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/riscv_i32_fetch_data_queue.sv
// Fetch-data queue: buffers fetch responses for decode, drops stale-epoch responses after flushes,
// and overlays debug-injected instructions on the decode output.
module riscv_i32_fetch_data_queue
  import riscv_i32_fetch_data_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 2
) (
  input logic                         clk,
  input logic                         reset_n,
  riscv_i32_fetch_data_queue_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [TAG_W-1:0] r_epoch;
  logic             r_overflow;

  logic      w_current;
  logic      w_empty;
  logic      w_not_full;
  logic      w_enq;
  logic      w_drop_full;
  logic      w_deq;
  fd_entry_t w_wdata;
  fd_entry_t w_rdata;
  fd_entry_t w_head;

  assign w_current   = bus.resp_valid && (bus.resp_tag == r_epoch) && !bus.flush;
  assign w_empty     = (r_count == '0);
  assign w_not_full  = (r_count != FULL);
  assign w_enq       = w_current && w_not_full;
  assign w_drop_full = w_current && !w_not_full;
  // Debug injection holds the queue head in place.
  assign w_deq       = !w_empty && bus.dec_ready && !bus.dbg_valid && !bus.flush;

  always_comb begin
    w_wdata                    = '0;
    w_wdata.pc                 = bus.resp_pc;
    w_wdata.data               = rewrite_debug_fetch(bus.resp_debug_fetch, bus.resp_pc,
                                                     bus.resp_data);
    w_wdata.error              = bus.resp_error;
    w_wdata.predicted_branch   = bus.resp_predicted_branch;
    w_wdata.pc_if_mispredicted = bus.resp_pc_if_mispredicted;
  end

  riscv_i32_fetch_data_queue_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk     (clk),
    .reset_n (reset_n),
    .i_we    (w_enq),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_epoch    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_drop_full) begin
        r_overflow <= 1'b1;
      end
      if (bus.flush) begin
        r_count  <= '0;
        r_rd_ptr <= r_wr_ptr;
        r_epoch  <= r_epoch + TAG_W'(1);
      end else begin
        if (w_enq) begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
        if (w_deq) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
        case ({w_enq, w_deq})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_comb begin
    w_head = w_empty ? '0 : w_rdata;

    bus.fd_valid              = bus.dbg_valid || (!bus.flush && !w_empty);
    bus.fd_pc                 = w_head.pc;
    bus.fd_data               = bus.dbg_valid ? bus.dbg_data : w_head.data;
    bus.fd_error              = w_head.error;
    bus.fd_predicted_branch   = w_head.predicted_branch;
    bus.fd_pc_if_mispredicted = w_head.pc_if_mispredicted;
    bus.fd_debug_valid        = bus.dbg_valid;
    bus.fd_debug_op           = bus.dbg_valid ? bus.dbg_op : DbgOpNone;
    bus.fd_debug_arg          = bus.dbg_valid ? bus.dbg_arg : 16'h0000;
    bus.fd_flush              = bus.flush;
    bus.fetch_ready           = w_not_full;
    bus.epoch                 = r_epoch;
    bus.overflow              = r_overflow;
  end

endmodule
